alu_bist: RTL
=============

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter NUM_VECTORS, default 16: number of pseudo-random operand pairs per run, range 1..65535.
REQ-002 Parameter SEED, default 32'hACE12468: LFSR load value at run start; must be nonzero.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-006 abort  in  1  stops a run and returns to IDLE.
REQ-007 data1, data2  out  32 each  registered operands driven to the ALU.
REQ-008 ALU_Control  out  4  registered opcode driven to the ALU.
REQ-009 shamt  out  5  registered shift amount driven to the ALU.
REQ-010 ALU_result  in  32; Control_error  in  1; zero  in  1: combinational ALU responses.
REQ-011 busy  out  1; done  out  1 (one-cycle pulse); pass  out  1.
REQ-012 fail_op  out  4; fail_vec  out  16: opcode and vector index of the first mismatch.

Function
REQ-013 The FSM SHALL use states IDLE, LOAD, DRIVE, CHECK, ILLEGAL_DRIVE, ILLEGAL_CHECK and DONE.
- IDLE->LOAD on start.
- LOAD->DRIVE after 1 cycle: load LFSR from SEED, vector index 0, op index 0.
- DRIVE->CHECK always.
- CHECK->DRIVE on match with ops or vectors remaining.
- CHECK->ILLEGAL_DRIVE on match after the last op of the last vector.
- CHECK->DONE on mismatch.
- ILLEGAL_DRIVE->ILLEGAL_CHECK.
- ILLEGAL_CHECK->DONE.
- DONE->IDLE after 1 cycle.
REQ-014 Op order per vector SHALL be AND 0000, OR 0001, add 0010, sub 0110, slt 0111, NOR 1100, sll 1101, rll 1110.
REQ-015 Per vector, data1 SHALL be the current LFSR state, data2 the next state, and shamt data1[4:0]; the LFSR SHALL advance two steps per vector using the Galois polynomial 32'h80200003.
REQ-016 Expected results:
- add/sub modulo 2^32.
- slt = 1 if signed data1 < signed data2, else 0.
- NOR = ~(data1|data2).
- sll = data2 << shamt.
- rll = data2 rotated left by shamt.
- expected zero = (expected result == 0).
- expected Control_error = 0.
REQ-017 In CHECK, ALU_result, zero and Control_error SHALL be sampled against the expected values; any single-bit difference is a mismatch.
REQ-018 ILLEGAL_DRIVE SHALL drive opcode 4'b0011; ILLEGAL_CHECK requires Control_error=1 and ignores ALU_result and zero.
REQ-019 A passing run SHALL pulse done exactly 16*NUM_VECTORS+3 cycles after the edge that samples start.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 pass SHALL be updated in DONE and held until the next accepted start, which clears it to 0.
REQ-022 On mismatch, the run SHALL stop at once; fail_op and fail_vec capture the failing op and index, pass=0, done pulses.
- An illegal-code failure records fail_op=4'b0011.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort SHALL win over start and over a same-cycle mismatch: IDLE next cycle, no done pulse, pass=0.
REQ-025 The vector index SHALL be 16-bit and SHALL NOT wrap within a run.

Reset
REQ-026 On rst_n=0 at a rising edge: state IDLE, all outputs 0 (busy, done, pass, fail_op, fail_vec, data1, data2, ALU_Control, shamt), LFSR=SEED.
- Reset mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-027 Macro ALU_BIST_ERRLOG_EN defined: add outputs err_data1, err_data2 and err_result (32 bits each), loaded with the failing operands and observed ALU_result on first mismatch, cleared on start and on reset.
- Macro undefined: these ports and registers are absent; all other behaviour is unchanged.

Structure
REQ-028 Shared package alu_pkg SHALL hold the opcode constants (including ALU_ILLEGAL=4'b0011), the LFSR tap constant and the FSM state encoding.
- The existing ALU SHALL use the same opcode constants.
REQ-029 One sub-module, alu_golden (combinational expected-result model), SHALL be instantiated inside alu_bist.

Verification
REQ-030 Correct ALU, NUM_VECTORS=2, start pulse -> done at cycle 35 after the start edge, pass=1, busy high for cycles 1..35.
REQ-031 ALU with sub forced to add -> stop at vector 0 op sub, fail_op=0110, fail_vec=0, pass=0, done after 9 cycles.
REQ-032 ALU with Control_error stuck 0 -> all ops pass, fail_op=0011, fail_vec=NUM_VECTORS, pass=0.
REQ-033 abort asserted in cycle 10 of a run -> IDLE at cycle 11, no done pulse, pass=0; a following start completes with pass=1.
REQ-034 rst_n low for one edge mid-run -> every output 0 next cycle; start while busy is ignored with no timing change.
REQ-035 With ALU_BIST_ERRLOG_EN and slt forced to unsigned compare on a vector where data1 < 0 and data2 > 0 -> err_result=0, err_data1/err_data2 equal the driven operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, BIST LFSR taps and BIST FSM state encoding.
// Used by the ALU, the golden model and alu_bist.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_ILLEGAL = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_SLL     = 4'b1101;
  localparam logic [3:0] ALU_RLL     = 4'b1110;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRIVE,
    CHECK,
    ILLEGAL_DRIVE,
    ILLEGAL_CHECK,
    DONE
  } bist_state_t;

  // Right-shifting Galois LFSR: the bit shifted out selects whether the taps are folded in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [3:0] op_at(input logic [2:0] idx);
    case (idx)
      3'd0:    return ALU_AND;
      3'd1:    return ALU_OR;
      3'd2:    return ALU_ADD;
      3'd3:    return ALU_SUB;
      3'd4:    return ALU_SLT;
      3'd5:    return ALU_NOR;
      3'd6:    return ALU_SLL;
      default: return ALU_RLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational expected-result model of the ALU for the legal opcodes.
// Illegal opcodes produce a zero result; the BIST ignores it for those.
module alu_golden
  import alu_pkg::*;
(
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [3:0]  op,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_AND: result = data1 & data2;
      ALU_OR:  result = data1 | data2;
      ALU_ADD: result = data1 + data2;
      ALU_SUB: result = data1 - data2;
      ALU_SLT: result = {31'd0, $signed(data1) < $signed(data2)};
      ALU_NOR: result = ~(data1 | data2);
      ALU_SLL: result = data2 << shamt;
      // Shifting right by 32 yields zero, which makes shamt == 0 a plain copy.
      ALU_RLL: result = (data2 << shamt) | (data2 >> (6'd32 - {1'b0, shamt}));
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_bist.sv
// Built-in self test for the 32-bit ALU: pseudo-random operands, every legal op, then the illegal code.
// Optional error log ports are enabled by defining ALU_BIST_ERRLOG_EN.
module alu_bist
  import alu_pkg::*;
#(
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [3:0]  ALU_Control,
  output logic [4:0]  shamt,
  input  logic [31:0] ALU_result,
  input  logic        Control_error,
  input  logic        zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_op,
`ifdef ALU_BIST_ERRLOG_EN
  output logic [31:0] err_data1,
  output logic [31:0] err_data2,
  output logic [31:0] err_result,
`endif
  output logic [15:0] fail_vec
);

  bist_state_t state, next_state;
  logic [31:0] lfsr;
  logic [15:0] vec_idx;
  logic [2:0]  op_idx;
  logic [31:0] exp_result;
  logic        exp_zero;
  logic        check_ok;
  logic        last_op;

  alu_golden u_golden (
    .data1  (data1),
    .data2  (data2),
    .op     (ALU_Control),
    .shamt  (shamt),
    .result (exp_result),
    .zero   (exp_zero)
  );

  assign check_ok = (ALU_result == exp_result) && (zero == exp_zero) && !Control_error;
  assign last_op  = (op_idx == 3'd7) && (vec_idx == 16'(NUM_VECTORS - 1));

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:          if (start) next_state = LOAD;
        LOAD:          next_state = DRIVE;
        DRIVE:         next_state = CHECK;
        CHECK: begin
          if (!check_ok)    next_state = DONE;
          else if (last_op) next_state = ILLEGAL_DRIVE;
          else              next_state = DRIVE;
        end
        ILLEGAL_DRIVE: next_state = ILLEGAL_CHECK;
        ILLEGAL_CHECK: next_state = DONE;
        DONE:          next_state = IDLE;
        default:       next_state = IDLE;
      endcase
    end
  end

  // NOTE: there are no memories here; every register, outputs included, is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr        <= SEED;
      vec_idx     <= 16'd0;
      op_idx      <= 3'd0;
      data1       <= 32'd0;
      data2       <= 32'd0;
      ALU_Control <= 4'd0;
      shamt       <= 5'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_op     <= 4'd0;
      fail_vec    <= 16'd0;
`ifdef ALU_BIST_ERRLOG_EN
      err_data1   <= 32'd0;
      err_data2   <= 32'd0;
      err_result  <= 32'd0;
`endif
    end else begin
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start && !abort) begin
            pass     <= 1'b0;
            fail_op  <= 4'd0;
            fail_vec <= 16'd0;
`ifdef ALU_BIST_ERRLOG_EN
            err_data1  <= 32'd0;
            err_data2  <= 32'd0;
            err_result <= 32'd0;
`endif
          end
        end
        LOAD: begin
          lfsr    <= SEED;
          vec_idx <= 16'd0;
          op_idx  <= 3'd0;
        end
        DRIVE: begin
          data1       <= lfsr;
          data2       <= lfsr_step(lfsr);
          shamt       <= lfsr[4:0];
          ALU_Control <= op_at(op_idx);
        end
        CHECK: begin
          if (!abort) begin
            if (check_ok) begin
              if (op_idx == 3'd7) begin
                // The index still advances after the last vector, so an illegal-code failure reports NUM_VECTORS.
                op_idx  <= 3'd0;
                vec_idx <= vec_idx + 16'd1;
                lfsr    <= lfsr_step(lfsr_step(lfsr));
              end else begin
                op_idx <= op_idx + 3'd1;
              end
            end else begin
              pass     <= 1'b0;
              fail_op  <= ALU_Control;
              fail_vec <= vec_idx;
`ifdef ALU_BIST_ERRLOG_EN
              err_data1  <= data1;
              err_data2  <= data2;
              err_result <= ALU_result;
`endif
            end
          end
        end
        ILLEGAL_DRIVE: ALU_Control <= ALU_ILLEGAL;
        ILLEGAL_CHECK: begin
          if (!abort) begin
            pass <= Control_error;
            if (!Control_error) begin
              fail_op  <= ALU_ILLEGAL;
              fail_vec <= vec_idx;
`ifdef ALU_BIST_ERRLOG_EN
              err_data1  <= data1;
              err_data2  <= data2;
              err_result <= ALU_result;
`endif
            end
          end
        end
        default: ;
      endcase
      if (abort && state != IDLE) pass <= 1'b0;
    end
  end

endmodule
